// File: rtl/sd_desc_fetch.sv
// sd_desc_fetch
//   Walks one storage-descriptor chain in sd_memory starting at a supplied
//   pointer. Reads are pipelined: sd_memory returns data exactly 2 cycles
//   after a read. Returned entries go into a small return buffer, and the
//   buffer head is streamed to the consumer with valid/ready. The walk stops
//   at the entry whose dcntl marks end-of-descriptor (EOM or SOM_EOM). Reads
//   already in flight at that point are discarded.
//
// Optional feature macro: SDF_ERR_CHECK_EN
//   When defined, a sticky error is raised in two cases:
//     - the first entry of a chain is not SOM/SOM_EOM;
//     - MAX_LEN entries are pushed without an end. The chain is then
//       truncated.
//   When undefined, chains are unbounded and sdf__xx__err is tied 0.
//
// Ports
//   clk, reset_poweron                  clock, async active-high reset
//   xx__sdf__valid/ptr, sdf__xx__ready  chain start request
//   sdf__sdm__read/addr                 read strobe and address to sd_memory
//   sdm__sdf__*                         sd_memory return (valid + entry fields)
//   sdf__cns__*, cns__sdf__ready        buffered entry stream to the consumer
//   sdf__xx__done                       1-cycle pulse when the chain completes
//   sdf__xx__err                        sticky chain error
//
// state  | meaning
// S_IDLE | waiting for a start request; ready=1
// S_FETCH| issuing reads under credit; pushing returns into the buffer
// S_DRAIN| end seen; discarding in-flight returns until the buffer empties
module sd_desc_fetch #(
  parameter int ADDR_W     = 10,
  parameter int OP_W       = 2,
  parameter int OPT_N      = 2,
  parameter int OPT_TYPE_W = 8,
  parameter int OPT_VAL_W  = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_LEN    = 64
) (
  input  logic                        clk,
  input  logic                        reset_poweron,
  input  logic                        xx__sdf__valid,
  input  logic [ADDR_W-1:0]           xx__sdf__ptr,
  output logic                        sdf__xx__ready,
  output logic                        sdf__sdm__read,
  output logic [ADDR_W-1:0]           sdf__sdm__addr,
  input  logic                        sdm__sdf__valid,
  input  logic [1:0]                  sdm__sdf__icntl,
  input  logic [1:0]                  sdm__sdf__dcntl,
  input  logic [OP_W-1:0]             sdm__sdf__op,
  input  logic [OPT_N*OPT_TYPE_W-1:0] sdm__sdf__opt_type,
  input  logic [OPT_N*OPT_VAL_W-1:0]  sdm__sdf__opt_val,
  output logic                        sdf__cns__valid,
  input  logic                        cns__sdf__ready,
  output logic [1:0]                  sdf__cns__icntl,
  output logic [1:0]                  sdf__cns__dcntl,
  output logic [OP_W-1:0]             sdf__cns__op,
  output logic [OPT_N*OPT_TYPE_W-1:0] sdf__cns__opt_type,
  output logic [OPT_N*OPT_VAL_W-1:0]  sdf__cns__opt_val,
  output logic                        sdf__xx__done,
  output logic                        sdf__xx__err
);

  localparam int ENT_W = 4 + OP_W + OPT_N*OPT_TYPE_W + OPT_N*OPT_VAL_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = FIFO_DEPTH[CNT_W:0];

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  outst_q;
  logic [CNT_W-1:0]  fifo_cnt_q;
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [ENT_W-1:0]  ret_ent, head_ent;

  logic accept, push, pop, rd, ret_end, ret_dec, credit_ok, stop_fetch, len_hit;
  logic fifo_empty;

  assign ret_ent    = {sdm__sdf__icntl, sdm__sdf__dcntl, sdm__sdf__op,
                       sdm__sdf__opt_type, sdm__sdf__opt_val};
  assign ret_end    = sdm__sdf__dcntl[1];
  assign fifo_empty = (fifo_cnt_q == '0);
  assign accept     = xx__sdf__valid && (state == S_IDLE);
  assign push       = (state == S_FETCH) && sdm__sdf__valid;
  assign pop        = !fifo_empty && cns__sdf__ready;
  // Guard against returns still in flight from before a reset: they arrive
  // with outstanding already cleared.
  assign ret_dec    = sdm__sdf__valid && (outst_q != '0);
  // Buffered plus in-flight entries must fit the buffer, so a push never
  // finds the buffer full.
  assign credit_ok  = ({1'b0, fifo_cnt_q} + {1'b0, outst_q}) < DEPTH_C;
  assign stop_fetch = push && (ret_end || len_hit);
  assign rd         = (state == S_FETCH) && credit_ok && !stop_fetch;

  always_comb begin
    state_nxt     = state;
    sdf__xx__done = 1'b0;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_FETCH;
      S_FETCH: if (stop_fetch) state_nxt = S_DRAIN;
      S_DRAIN: begin
        if ((outst_q == '0) && fifo_empty) begin
          sdf__xx__done = 1'b1;
          state_nxt     = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      outst_q    <= '0;
      fifo_cnt_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      state <= state_nxt;
      if (accept)  addr_q <= xx__sdf__ptr;
      else if (rd) addr_q <= addr_q + 1'b1;
      case ({rd, ret_dec})
        2'b10:   outst_q <= outst_q + 1'b1;
        2'b01:   outst_q <= outst_q - 1'b1;
        default: outst_q <= outst_q;
      endcase
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // Storage needs no reset: the head is masked while the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr_q] <= ret_ent;
  end

  assign head_ent = fifo_empty ? '0 : fifo_mem[rptr_q];

  assign sdf__xx__ready  = (state == S_IDLE);
  assign sdf__sdm__read  = rd;
  assign sdf__sdm__addr  = rd ? addr_q : '0;
  assign sdf__cns__valid = !fifo_empty;
  assign {sdf__cns__icntl, sdf__cns__dcntl, sdf__cns__op,
          sdf__cns__opt_type, sdf__cns__opt_val} = head_ent;

`ifdef SDF_ERR_CHECK_EN
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] MAX_LEN_C = MAX_LEN[LEN_W-1:0];

  // Entries left before the chain is truncated. This is a down-counter
  // with a terminal count at 1.
  logic [LEN_W-1:0] len_left_q;
  logic             first_q;
  logic             err_q;

  assign len_hit = push && !ret_end && (len_left_q == LEN_W'(1));

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      len_left_q <= '0;
      first_q    <= 1'b0;
      err_q      <= 1'b0;
    end else if (accept) begin
      len_left_q <= MAX_LEN_C;
      first_q    <= 1'b1;
      err_q      <= 1'b0;
    end else if (push) begin
      len_left_q <= len_left_q - 1'b1;
      first_q    <= 1'b0;
      // dcntl[0] set means SOM or SOM_EOM.
      if ((first_q && !sdm__sdf__dcntl[0]) || len_hit) err_q <= 1'b1;
    end
  end

  assign sdf__xx__err = err_q;
`else
  assign len_hit      = 1'b0;
  assign sdf__xx__err = 1'b0;
`endif

endmodule

// File: tb/tb_sd_desc_fetch.sv
module tb_sd_desc_fetch;

  localparam int ADDR_W  = 10;
  localparam int ENT_W   = 70;
  localparam int DEPTH   = 4;
  localparam int MAX_LEN = 64;

  logic              clk = 1'b0;
  logic              reset_poweron = 1'b1;
  logic              xx__sdf__valid = 1'b0;
  logic [ADDR_W-1:0] xx__sdf__ptr = '0;
  logic              sdf__xx__ready;
  logic              sdf__sdm__read;
  logic [ADDR_W-1:0] sdf__sdm__addr;
  logic              sdm__sdf__valid;
  logic [1:0]        sdm__sdf__icntl, sdm__sdf__dcntl;
  logic [1:0]        sdm__sdf__op;
  logic [15:0]       sdm__sdf__opt_type;
  logic [47:0]       sdm__sdf__opt_val;
  logic              sdf__cns__valid;
  logic              cns__sdf__ready = 1'b0;
  logic [1:0]        sdf__cns__icntl, sdf__cns__dcntl;
  logic [1:0]        sdf__cns__op;
  logic [15:0]       sdf__cns__opt_type;
  logic [47:0]       sdf__cns__opt_val;
  logic              sdf__xx__done;
  logic              sdf__xx__err;

  sd_desc_fetch dut (
    .clk(clk), .reset_poweron(reset_poweron),
    .xx__sdf__valid(xx__sdf__valid), .xx__sdf__ptr(xx__sdf__ptr),
    .sdf__xx__ready(sdf__xx__ready),
    .sdf__sdm__read(sdf__sdm__read), .sdf__sdm__addr(sdf__sdm__addr),
    .sdm__sdf__valid(sdm__sdf__valid), .sdm__sdf__icntl(sdm__sdf__icntl),
    .sdm__sdf__dcntl(sdm__sdf__dcntl), .sdm__sdf__op(sdm__sdf__op),
    .sdm__sdf__opt_type(sdm__sdf__opt_type), .sdm__sdf__opt_val(sdm__sdf__opt_val),
    .sdf__cns__valid(sdf__cns__valid), .cns__sdf__ready(cns__sdf__ready),
    .sdf__cns__icntl(sdf__cns__icntl), .sdf__cns__dcntl(sdf__cns__dcntl),
    .sdf__cns__op(sdf__cns__op), .sdf__cns__opt_type(sdf__cns__opt_type),
    .sdf__cns__opt_val(sdf__cns__opt_val),
    .sdf__xx__done(sdf__xx__done), .sdf__xx__err(sdf__xx__err)
  );

  always #5 clk = ~clk;

  // sd_memory model: fixed 2-cycle read latency, not affected by reset
  logic [ENT_W-1:0]  sd_mem [1024];
  logic              p1_v = 1'b0, p2_v = 1'b0;
  logic [ADDR_W-1:0] p1_a = '0;
  logic [ENT_W-1:0]  p2_d = '0;

  always @(posedge clk) begin
    p1_v <= sdf__sdm__read;
    p1_a <= sdf__sdm__addr;
    p2_v <= p1_v;
    p2_d <= sd_mem[p1_a];
  end

  assign sdm__sdf__valid = p2_v;
  assign {sdm__sdf__icntl, sdm__sdf__dcntl, sdm__sdf__op,
          sdm__sdf__opt_type, sdm__sdf__opt_val} = p2_d;

  logic [ENT_W-1:0] cns_ent;
  assign cns_ent = {sdf__cns__icntl, sdf__cns__dcntl, sdf__cns__op,
                    sdf__cns__opt_type, sdf__cns__opt_val};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [ENT_W-1:0] got, input logic [ENT_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard state
  logic [ENT_W-1:0]  exp_q[$];
  int                n_exp;
  logic              exp_err;
  logic [ADDR_W-1:0] exp_addr;
  bit                mon_en = 1'b0;
  int cyc = 0;
  int reads, pops, done_cnt, max_infl, hold_viol;
  int acc_cyc, first_rcyc, first_vcyc, first_pcyc, last_pcyc;
  bit               prev_stall;
  logic [ENT_W-1:0] prev_ent;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en && !reset_poweron) begin
      if (xx__sdf__valid && sdf__xx__ready) acc_cyc = cyc;
      if (sdf__sdm__read) begin
        if (first_rcyc < 0) first_rcyc = cyc;
        chk("rd_addr", ENT_W'(sdf__sdm__addr), ENT_W'(exp_addr));
        exp_addr = exp_addr + 1'b1;
        reads++;
      end
      if (sdf__cns__valid && first_vcyc < 0) first_vcyc = cyc;
      if (prev_stall && (!sdf__cns__valid || cns_ent !== prev_ent)) hold_viol++;
      if (sdf__cns__valid && cns__sdf__ready) begin
        if (exp_q.size() == 0) chk("extra_entry", ENT_W'(pops + 1), ENT_W'(n_exp));
        else chk("entry", cns_ent, exp_q.pop_front());
        pops++;
        if (first_pcyc < 0) first_pcyc = cyc;
        last_pcyc = cyc;
      end
      prev_stall = sdf__cns__valid && !cns__sdf__ready;
      prev_ent   = cns_ent;
      if (reads - pops > max_infl) max_infl = reads - pops;
      if (sdf__xx__done) begin
        done_cnt++;
        chk("done_after_last", ENT_W'(exp_q.size()), '0);
      end
    end
  end

  // Lays out a chain in sd_memory (plus random trailing entries) and derives
  // the expected entry list by walking the memory with the chain rules.
  task automatic build_chain(input logic [ADDR_W-1:0] ptr, input int len,
                             input bit first_bad, input bit no_end);
    logic [ENT_W-1:0]  e;
    logic [ADDR_W-1:0] a;
    int                n_ent;
    n_ent = no_end ? MAX_LEN + 8 : len;
    for (int k = 0; k < n_ent + 8; k++) begin
      a = ptr + ADDR_W'(k);
      e = ENT_W'({$urandom, $urandom, $urandom});
      if (k < n_ent) begin
        if (no_end)              e[67:66] = (k == 0) ? 2'b01 : 2'b00;
        else if (k == n_ent - 1) e[67:66] = (n_ent == 1) ? (first_bad ? 2'b10 : 2'b11) : 2'b10;
        else                     e[67:66] = (k == 0 && !first_bad) ? 2'b01 : 2'b00;
      end
      sd_mem[a] = e;
    end
    exp_q.delete();
    a = ptr;
    for (int n = 0; n < 1024; n++) begin
      exp_q.push_back(sd_mem[a]);
      if (sd_mem[a][67]) break;
`ifdef SDF_ERR_CHECK_EN
      if (n + 1 == MAX_LEN) break;
`endif
      a = a + 1'b1;
    end
    n_exp   = exp_q.size();
    exp_err = 1'b0;
`ifdef SDF_ERR_CHECK_EN
    exp_err = !exp_q[0][66] || !exp_q[n_exp-1][67];
`endif
  endtask

  task automatic start_chain(input logic [ADDR_W-1:0] ptr);
    exp_addr = ptr; reads = 0; pops = 0; done_cnt = 0; max_infl = 0; hold_viol = 0;
    acc_cyc = -1; first_rcyc = -1; first_vcyc = -1; first_pcyc = -1; last_pcyc = -1;
    prev_stall = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    xx__sdf__valid = 1'b1;
    xx__sdf__ptr   = ptr;
    @(posedge clk); #1;
    xx__sdf__valid = 1'b0;
  endtask

  // rmode: 0 always ready, 1 toggle, 2 random, 3 held low for 10 cycles
  task automatic run_chain(input logic [ADDR_W-1:0] ptr, input int len, input int rmode,
                           input bit first_bad, input bit no_end);
    int after;
    build_chain(ptr, len, first_bad, no_end);
    start_chain(ptr);
    after = 0;
    for (int k = 0; k < 3000; k++) begin
      case (rmode)
        0:       cns__sdf__ready = 1'b1;
        1:       cns__sdf__ready = (k % 2) == 0;
        2:       cns__sdf__ready = $urandom_range(0, 1) == 1;
        default: cns__sdf__ready = (k >= 10);
      endcase
      @(posedge clk); #1;
      if (done_cnt > 0) after++;
      if (after == 3) break;
    end
    chk("done_count", ENT_W'(done_cnt), 1);
    chk("entries_left", ENT_W'(exp_q.size()), '0);
    chk("inflight_le_depth", ENT_W'(max_infl <= DEPTH), 1);
    chk("hold_stable", ENT_W'(hold_viol), '0);
    chk("ready_idle", ENT_W'(sdf__xx__ready), 1);
    chk("err", ENT_W'(sdf__xx__err), ENT_W'(exp_err));
    chk("lat_read", ENT_W'(first_rcyc - acc_cyc), 1);
    chk("lat_valid", ENT_W'(first_vcyc - acc_cyc), 4);
    if (rmode == 0) begin
      chk("read_count", ENT_W'(reads), ENT_W'(n_exp + 1));
      chk("burst_rate", ENT_W'(last_pcyc - first_pcyc), ENT_W'(n_exp - 1));
    end
    mon_en = 1'b0;
  endtask

  task automatic reset_mid_chain();
    bit got_v;
    build_chain(10'h100, 8, 1'b0, 1'b0);
    cns__sdf__ready = 1'b0;
    start_chain(10'h100);
    got_v = 1'b0;
    for (int k = 0; k < 50 && !got_v; k++) begin
      @(negedge clk);
      got_v = sdf__cns__valid;
    end
    chk("rst_fill_timeout", ENT_W'(got_v), 1);
    mon_en = 1'b0;
    @(posedge clk); #1;
    reset_poweron = 1'b1;
    @(negedge clk);
    chk("rst_cns_valid", ENT_W'(sdf__cns__valid), '0);
    chk("rst_ready", ENT_W'(sdf__xx__ready), 1);
    chk("rst_read", ENT_W'(sdf__sdm__read), '0);
    @(posedge clk); #1;
    reset_poweron = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("stale_ignored", ENT_W'(sdf__cns__valid), '0);
    chk("post_rst_ready", ENT_W'(sdf__xx__ready), 1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) sd_mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", ENT_W'(sdf__xx__ready), 1);
    chk("reset_cns_valid", ENT_W'(sdf__cns__valid), '0);
    chk("reset_read", ENT_W'(sdf__sdm__read), '0);
    chk("reset_done", ENT_W'(sdf__xx__done), '0);
    chk("reset_err", ENT_W'(sdf__xx__err), '0);
    @(posedge clk); #1;
    reset_poweron = 1'b0;

    run_chain(10'h010, 3, 0, 1'b0, 1'b0);
    run_chain(10'h3FE, 4, 0, 1'b0, 1'b0);
    run_chain(10'h155, 1, 3, 1'b0, 1'b0);
    run_chain(10'h200, 8, 1, 1'b0, 1'b0);
    reset_mid_chain();
    run_chain(10'h020, 5, 0, 1'b0, 1'b0);
    for (int t = 0; t < 24; t++) begin
      run_chain(ADDR_W'($urandom), $urandom_range(1, 12), $urandom_range(0, 3),
                $urandom_range(0, 3) == 0, 1'b0);
    end
`ifdef SDF_ERR_CHECK_EN
    run_chain(10'h300, 0, 0, 1'b0, 1'b1);
    run_chain(10'h040, 3, 0, 1'b0, 1'b0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
